// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_txn_arbiter
// Purpose  : Round-robin sharing of one byte-level I2C master engine between
//            NREQ requesters. Each transaction is a single byte. A watchdog
//            aborts the engine if it hangs. Status and read data are routed
//            back to the requester that was granted.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_txn_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 15000,
  parameter int CW      = 14
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NREQ-1:0]     req,
  input  logic [7*NREQ-1:0]   req_addr,
  input  logic [NREQ-1:0]     req_rw,
  input  logic [8*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [7:0]          rsp_rdata,
  output logic                rsp_nack,
  output logic                rsp_timeout,
  output logic                eng_start,
  output logic [6:0]          eng_addr,
  output logic                eng_rw,
  output logic [7:0]          eng_wdata,
  output logic                eng_abort,
  input  logic                eng_busy,
  input  logic                eng_done,
  input  logic                eng_nack,
  input  logic [7:0]          eng_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0]   PTR_RST  = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  logic [1:0]      r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_gidx;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [7:0]      r_rsp_rdata;
  logic            r_rsp_nack;
  logic            r_rsp_timeout;
  logic            r_eng_start;
  logic [6:0]      r_eng_addr;
  logic            r_eng_rw;
  logic [7:0]      r_eng_wdata;
  logic            r_eng_abort;

  logic [6:0]      w_addr_a  [NREQ];
  logic [7:0]      w_wdata_a [NREQ];
  logic            w_found;
  logic [PW-1:0]   w_pick;
  logic [PW-1:0]   w_cand;
  int              w_sum;

  // Split the packed request buses into per-requester fields
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_addr_a[gi]  = req_addr[7*gi +: 7];
    assign w_wdata_a[gi] = req_wdata[8*gi +: 8];
  end

  // Round-robin pick: first requesting index after r_ptr, wrapping modulo NREQ
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    w_sum   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      w_cand = PW'(w_sum);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Transaction sequencer: arbitrate, issue, supervise, respond
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= PTR_RST;
      r_gidx        <= '0;
      r_cnt         <= '0;
      r_gnt         <= '0;
      r_done        <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_nack    <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_eng_start   <= 1'b0;
      r_eng_addr    <= '0;
      r_eng_rw      <= 1'b0;
      r_eng_wdata   <= '0;
      r_eng_abort   <= 1'b0;
    end else begin
      // Strobes default low so every pulse lasts exactly one cycle
      r_gnt       <= '0;
      r_done      <= '0;
      r_eng_start <= 1'b0;
      r_eng_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gidx      <= w_pick;
            r_eng_addr  <= w_addr_a[w_pick];
            r_eng_rw    <= req_rw[w_pick];
            r_eng_wdata <= w_wdata_a[w_pick];
            r_gnt       <= ONE_HOT0 << w_pick;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!eng_busy) begin
            r_eng_start <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A completion in the watchdog's last cycle still counts as success
          if (eng_done) begin
            r_rsp_nack    <= eng_nack;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= r_eng_rw ? eng_rdata : 8'h00;
            r_done        <= ONE_HOT0 << r_gidx;
            r_state       <= S_RESP;
          end else if (r_cnt == TMO_LAST) begin
            r_eng_abort   <= 1'b1;
            r_rsp_nack    <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= 8'h00;
            r_done        <= ONE_HOT0 << r_gidx;
            r_state       <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          // RESP: done is visible this cycle; winner becomes lowest priority
          r_ptr   <= r_gidx;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_nack    = r_rsp_nack;
  assign rsp_timeout = r_rsp_timeout;
  assign eng_start   = r_eng_start;
  assign eng_addr    = r_eng_addr;
  assign eng_rw      = r_eng_rw;
  assign eng_wdata   = r_eng_wdata;
  assign eng_abort   = r_eng_abort;

endmodule
`default_nettype wire

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares the single byte-level I2C master engine (the block driving scl/sda) between NREQ independent requesters.
- Each requester submits one single-byte transaction: 7-bit slave address, read/write, write data.
- The block arbitrates round-robin, issues the transaction to the engine, supervises it with a watchdog timeout, and routes completion status and read data back to the winning requester.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 15000, clk cycles allowed between eng_start and eng_done before the transaction is aborted (300 us at 50 MHz).
- CW, 14, width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request; held high until the matching gnt bit pulses.
- req_addr  input  7*NREQ  slave address; requester i occupies bits [7i+6:7i].
- req_rw  input  NREQ  1 = read, 0 = write.
- req_wdata  input  8*NREQ  write byte; requester i occupies bits [8i+7:8i].
- gnt  output  NREQ  one-cycle pulse: request accepted and fields latched.
- done  output  NREQ  one-cycle pulse: transaction finished.
- rsp_rdata  output  8  read byte, valid in the done cycle and held until the next gnt.
- rsp_nack  output  1  slave NACK or timeout, valid and held as rsp_rdata.
- rsp_timeout  output  1  watchdog expired, valid and held as rsp_rdata.
- eng_start  output  1  one-cycle command strobe to the engine.
- eng_addr  output  7  latched address, stable from gnt until the done cycle.
- eng_rw  output  1  latched read/write, stable as eng_addr.
- eng_wdata  output  8  latched write byte, stable as eng_addr.
- eng_abort  output  1  one-cycle pulse: engine must issue STOP and return idle.
- eng_busy  input  1  engine is mid-transaction.
- eng_done  input  1  one-cycle pulse: engine finished.
- eng_nack  input  1  slave NACK status, valid with eng_done.
- eng_rdata  input  8  read byte, valid with eng_done.

Behaviour:
- Reset (asynchronous, n_rst low):
  - State = IDLE.
  - All outputs 0.
  - Round-robin pointer ptr = NREQ-1, so requester 0 wins first.
  - Timeout counter = 0.
  - Reset mid-transaction discards the transaction; no done is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - When |req, select the first set bit scanning ptr+1, ptr+2, ... modulo NREQ. Call it index g.
  - Latch that requester's fields into eng_addr, eng_rw and eng_wdata.
  - Pulse gnt[g] for one cycle; go to ISSUE.
  - gnt appears one cycle after req is sampled high.
- ISSUE:
  - If eng_busy=1, wait with eng_start low.
  - If eng_busy=0, pulse eng_start for one cycle, clear the counter, go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - On eng_done:
    - Capture rsp_nack = eng_nack and rsp_timeout = 0.
    - Capture rsp_rdata = eng_rdata if eng_rw=1, else 8'h00.
    - Go to RESP.
  - If the counter reaches TIMEOUT-1 without eng_done:
    - Pulse eng_abort.
    - Set rsp_nack=1, rsp_timeout=1, rsp_rdata=8'h00.
    - Go to RESP.
  - If eng_done and the timeout occur in the same cycle, eng_done wins and eng_abort stays low.
- RESP:
  - Pulse done[g] for one cycle.
  - Set ptr = g; go to IDLE.
  - The earliest next gnt is the cycle after RESP.
- eng_done seen outside WAIT is ignored.
- req changes outside IDLE are ignored. A requester still asserting req after its done is treated as a new request and competes under the round-robin rule.
- Only one gnt bit and one done bit are ever high, and only one transaction is outstanding at a time.
- Minimum latency, counted from req sampled at cycle 0 with the engine idle:
  - gnt at cycle 1.
  - eng_start at cycle 2.
  - done at eng_done + 1.

Test Plan:
- Single write: req[0] with addr 7'h50, rw=0, wdata 8'hA5; engine model returns done after 400 cycles with nack=0 -> gnt[0] at cycle 1, eng_start at cycle 2 with addr 50/rw 0/wdata A5, done[0] one cycle after eng_done, rsp_nack=0, rsp_rdata=00.
- Read with NACK: req[1] read from 7'h3C; engine returns nack=1, rdata 8'h5A -> done[1], rsp_nack=1, rsp_rdata=5A, rsp_timeout=0.
- Fairness: req=2'b11 held continuously for 4 transactions -> grant order 0,1,0,1 with no back-to-back repeat.
- Timeout: engine never pulses eng_done -> eng_abort pulses exactly TIMEOUT cycles after eng_start, then done pulses with rsp_nack=1, rsp_timeout=1.
- Busy hold and tie: eng_busy=1 for 50 cycles after gnt -> eng_start only in the first cycle after busy falls. Separately, eng_done coincident with the timeout cycle -> no eng_abort, rsp_timeout=0.
- Reset in WAIT: drop n_rst for 12 ns mid-transaction -> all outputs 0 immediately, no done, and requester 0 wins the next arbitration.
